// File: rtl/sensor_conditioner.sv
// Front-end conditioner for the three field sensors: two-flop synchronisers,
// tick-sampled persistence filters, and a capture snapshot for downstream logic.
module sensor_conditioner #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int STABLE_COUNT = 8
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       soil_humidity_i,
  input  logic       air_humidity_i,
  input  logic       temperature_i,
  input  logic       capture_i,
  output logic       soil_f,
  output logic       air_f,
  output logic       temp_f,
  output logic [2:0] snap,
  output logic       snap_valid,
  output logic       ready,
  output logic       change_pulse
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [7:0]    STABLE_M1  = 8'(STABLE_COUNT - 1);

  typedef enum logic {ST_SETTLE, ST_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [2:0]      r_sync1, r_sync2;
  logic [2:0]      r_filt, r_snap;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_settle;
  logic [2:0][7:0] r_cnt;
  logic            r_snap_valid, r_change;
  logic            w_tick, w_settle_done;
  logic [2:0]      w_upd;

  assign w_tick        = (r_presc == PRESC_LAST);
  assign w_settle_done = (r_state == ST_SETTLE) && w_tick && (r_settle == STABLE_M1);

  // A channel flips when this tick would be its STABLE_COUNT-th disagreement.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    w_upd = '0;
    for (int i = 0; i < 3; i++) begin
      w_upd[i] = (r_state == ST_RUN) && w_tick && (r_sync2[i] != r_filt[i]) &&
                 (r_cnt[i] == STABLE_M1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_settle_done) w_state_next = ST_RUN;
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) r_state <= ST_SETTLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_filt       <= '0;
      r_snap       <= '0;
      r_presc      <= '0;
      r_settle     <= '0;
      r_cnt        <= '0;
      r_snap_valid <= 1'b0;
      r_change     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_sync1  <= {temperature_i, air_humidity_i, soil_humidity_i};
      r_sync2  <= r_sync1;
      r_presc  <= w_tick ? '0 : r_presc + 1'b1;
      r_change <= |w_upd;

      if (r_state == ST_SETTLE) begin
        if (w_tick) r_settle <= r_settle + 8'd1;
        if (w_settle_done) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end
      end else if (w_tick) begin
        for (int i = 0; i < 3; i++) begin
          if (r_sync2[i] == r_filt[i]) begin
            r_cnt[i] <= '0;
          end else if (w_upd[i]) begin
            r_filt[i] <= r_sync2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end
      end

      // Snapshot takes the pre-update filtered value even on a flip cycle.
      if (capture_i && (r_state == ST_RUN)) begin
        r_snap       <= r_filt;
        r_snap_valid <= 1'b1;
      end
    end
  end

  assign soil_f       = r_filt[0];
  assign air_f        = r_filt[1];
  assign temp_f       = r_filt[2];
  assign snap         = r_snap;
  assign snap_valid   = r_snap_valid;
  assign ready        = (r_state == ST_RUN);
  assign change_pulse = r_change;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: a tick-level behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sensor_conditioner;

  localparam int DIV = 10;
  localparam int STC = 4;

  logic       clk_50mhz = 1'b0;
  logic       rst = 1'b1;
  logic       soil_humidity_i = 1'b0, air_humidity_i = 1'b0, temperature_i = 1'b0;
  logic       capture_i = 1'b0;
  logic       soil_f, air_f, temp_f, snap_valid, ready, change_pulse;
  logic [2:0] snap;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  sensor_conditioner #(.SAMPLE_DIV(DIV), .STABLE_COUNT(STC)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst),
    .soil_humidity_i(soil_humidity_i), .air_humidity_i(air_humidity_i),
    .temperature_i(temperature_i), .capture_i(capture_i),
    .soil_f(soil_f), .air_f(air_f), .temp_f(temp_f),
    .snap(snap), .snap_valid(snap_valid), .ready(ready), .change_pulse(change_pulse)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles since reset, sync = raw input two edges old, a tick every
  // DIV-th edge; a filtered bit flips after STC consecutive disagreeing ticks.
  int         m_cyc, m_settle;
  int         m_run [3];
  logic [2:0] m_s1, m_s2, m_filt, m_snap, m_now;
  logic       m_ready, m_valid, m_change, m_tick;

  always @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_settle = 0; m_s1 = '0; m_s2 = '0; m_filt = '0; m_snap = '0;
      m_ready = 0; m_valid = 0; m_change = 0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      m_tick = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      m_now = m_s2;
      m_s2 = m_s1;
      m_s1 = {temperature_i, air_humidity_i, soil_humidity_i};
      m_change = 0;
      if (capture_i && m_ready) begin
        m_snap = m_filt;
        m_valid = 1;
      end
      if (m_tick && !m_ready) begin
        m_settle++;
        if (m_settle == STC) begin
          m_filt = m_now;
          m_ready = 1;
        end
      end else if (m_tick) begin
        for (int i = 0; i < 3; i++) begin
          if (m_now[i] != m_filt[i]) begin
            m_run[i]++;
            if (m_run[i] == STC) begin
              m_filt[i] = m_now[i];
              m_run[i] = 0;
              m_change = 1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk_50mhz) begin
    if (change_pulse === 1'b1) n_pulses++;
    check("m_soil_f", 8'(soil_f), 8'(m_filt[0]));
    check("m_air_f", 8'(air_f), 8'(m_filt[1]));
    check("m_temp_f", 8'(temp_f), 8'(m_filt[2]));
    check("m_snap", 8'(snap), 8'(m_snap));
    check("m_snap_valid", 8'(snap_valid), 8'(m_valid));
    check("m_ready", 8'(ready), 8'(m_ready));
    check("m_change_pulse", 8'(change_pulse), 8'(m_change));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_50mhz);
  endtask

  // Advance to the negedge just after a tick edge.
  task automatic after_tick();
    int k;
    k = 0;
    while ((m_cyc % DIV) != DIV - 1 && k < 2 * DIV) begin
      step(1);
      k++;
    end
    check("tick_found", 8'(k < 2 * DIV), 8'd1);
    step(1);
  endtask

  int p0;

  initial begin
    // Test 1 / 4a: settle with soil=1 air=0 temp=1; capture ignored in SETTLE.
    soil_humidity_i = 1; air_humidity_i = 0; temperature_i = 1;
    #23;
    check("rst_ready", 8'(ready), 8'd0);
    check("rst_outs", 8'({temp_f, air_f, soil_f, snap, snap_valid, change_pulse}), 8'd0);
    step(1);
    rst = 0;
    step(5);
    capture_i = 1;
    step(1);
    capture_i = 0;
    check("settle_snap", 8'(snap), 8'd0);
    check("settle_snap_valid", 8'(snap_valid), 8'd0);
    step(33);
    check("ready_edge39", 8'(ready), 8'd0);
    check("filt_edge39", 8'({temp_f, air_f, soil_f}), 8'd0);
    step(1);
    check("ready_edge40", 8'(ready), 8'd1);
    check("filt_initial", 8'({temp_f, air_f, soil_f}), 8'h5);
    check("no_initial_pulse", 8'(n_pulses), 8'd0);

    // Test 4b: capture in RUN.
    step(3);
    capture_i = 1;
    step(1);
    capture_i = 0;
    check("run_snap", 8'(snap), 8'h5);
    check("run_snap_valid", 8'(snap_valid), 8'd1);

    // Test 2: soil glitch spanning only three ticks.
    after_tick();
    p0 = n_pulses;
    soil_humidity_i = 0;
    step(30);
    soil_humidity_i = 1;
    step(25);
    check("glitch_soil_f", 8'(soil_f), 8'd1);
    check("glitch_pulses", 8'(n_pulses - p0), 8'd0);

    // Test 3: air rises and holds.
    after_tick();
    p0 = n_pulses;
    air_humidity_i = 1;
    step(39);
    check("air_before_flip", 8'(air_f), 8'd0);
    step(1);
    check("air_after_flip", 8'(air_f), 8'd1);
    check("air_pulse_now", 8'(change_pulse), 8'd1);
    step(15);
    check("air_pulse_count", 8'(n_pulses - p0), 8'd1);

    // Test 5: capture on the same edge that flips temp 1->0.
    after_tick();
    temperature_i = 0;
    step(39);
    capture_i = 1;
    step(1);
    capture_i = 0;
    check("flip_snap_old", 8'(snap), 8'h7);
    check("flip_temp_f", 8'(temp_f), 8'd0);
    step(7);

    // Test 6: asynchronous reset between edges mid-RUN.
    @(posedge clk_50mhz);
    #2 rst = 1;
    #1;
    check("async_rst_outs",
          8'({temp_f, air_f, soil_f, snap, snap_valid, change_pulse}), 8'd0);
    check("async_rst_ready", 8'(ready), 8'd0);
    step(2);
    rst = 0;
    step(39);
    check("rerun_ready39", 8'(ready), 8'd0);
    step(1);
    check("rerun_ready40", 8'(ready), 8'd1);
    check("rerun_filt", 8'({temp_f, air_f, soil_f}), 8'h3);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
